ad_cfg_seq: RTL and testbench
=============================

Name: ad_cfg_seq

Overview:
- Upstream configuration sequencer for the ADC serial-port writer. It walks a register table of {addr[5:0], data[7:0]} entries, one per SPI frame.
- Per entry: issues a single-cycle write request carrying addr/data, then holds off for a fixed gap so the downstream SPI frame (about 53 cycles of CSB-low activity) completes before the next request.
- Runs once after power-up or reset, and again on every accepted start pulse.

Parameters:
- NUM_REGS, 16, number of table entries written per sequence (1..2^IDX_W).
- IDX_W, 5, width of table index.
- GAP_CYCLES, 64, cycles from a wr_en pulse to the next FETCH. Legal range 56..1023.
- PWR_DLY, 1000, cycles waited after start before the first FETCH. 0 = no wait. Legal range 0..2^20-1.
- AUTO_START, 1, 1 = behave as if start was sampled in the first cycle after reset is released.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request a full configuration pass. Sampled only in IDLE or DONE.
- tbl_idx  out  IDX_W  table read index.
- tbl_addr  in  6  register address for tbl_idx. Registered table; valid one cycle after tbl_idx.
- tbl_data  in  8  register data for tbl_idx. Same timing as tbl_addr.
- wr_en  out  1  single-cycle write request to the SPI writer.
- addr  out  6  register address. Valid in the wr_en cycle; held until the next wr_en.
- data  out  8  register data. Valid in the wr_en cycle; held until the next wr_en.
- busy  out  1  high from start acceptance until the last gap has expired.
- done  out  1  sticky completion flag.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) sets:
  - state IDLE, wr_en=0, addr=0, data=0, tbl_idx=0, busy=0, done=0, all counters 0.
  - Clock and reset are fixed: one clock clk; rst synchronous, active-high.
- States: IDLE, PWR_WAIT, FETCH, ISSUE, GAP, DONE.
- IDLE:
  - start=1 (or the first cycle after reset with AUTO_START=1) → busy=1, done=0, entry count=0.
  - Go to PWR_WAIT if PWR_DLY>0, else FETCH.
- PWR_WAIT: 20-bit counter runs from 0 to PWR_DLY-1, then → FETCH. Occupies exactly PWR_DLY cycles.
- FETCH: tbl_idx = entry count (driven from the registered counter). One cycle, then → ISSUE.
- ISSUE:
  - Register tbl_addr→addr, tbl_data→data, 1→wr_en.
  - These values are visible on the outputs in the next cycle, which is the first GAP cycle.
- GAP:
  - wr_en=0 after its single cycle.
  - 10-bit counter runs to GAP_CYCLES-1 (GAP_CYCLES cycles, counted from the wr_en cycle).
  - On expiry: if entry count == NUM_REGS-1 → DONE. Otherwise entry count +1 → FETCH.
- DONE: busy=0, done=1 (held).
  - start=1 → clear done, reset entry count, busy=1, proceed exactly as from IDLE.
- Timing, with start sampled at cycle N and PWR_DLY=0:
  - FETCH at N+1, ISSUE at N+2, first wr_en visible at N+3.
  - With PWR_DLY=P: first wr_en at N+3+P.
  - Period between wr_en pulses = GAP_CYCLES+2.
  - done rises GAP_CYCLES cycles after the last wr_en.
- start while busy (PWR_WAIT/FETCH/ISSUE/GAP) is ignored, with no queuing.
- start held high continuously: in DONE it retriggers immediately, giving back-to-back passes.
- rst mid-sequence: immediate return to IDLE with the reset values above.
  - If the downstream frame is in flight, it completes on its own. The sequencer does not track it.
  - With AUTO_START=1 a fresh pass starts after rst is released.
- wr_en is never asserted outside ISSUE→GAP and is never high in two consecutive cycles.
- tbl_idx never exceeds NUM_REGS-1.
- addr/data never change except in the cycle wr_en rises.

Test Plan:
- NUM_REGS=3, PWR_DLY=0, GAP=64, AUTO_START=0; table {0x00/0x3C, 0x14/0x01, 0x16/0x80}; start pulse at cycle 10 →
  - wr_en at cycles 13, 79, 145 with matching addr/data;
  - done=1 and busy=0 at cycle 209.
- PWR_DLY=100, start at cycle 10 → first wr_en at cycle 113; busy=1 from cycle 11.
- start pulsed at the second wr_en cycle and again mid-gap → no extra wr_en; total of 3 pulses; done timing unchanged.
- rst asserted for 1 cycle during GAP after entry 1 (AUTO_START=0) → all outputs at reset values next cycle; no further wr_en until a new start; that pass restarts at tbl_idx=0.
- AUTO_START=1, PWR_DLY=0: release rst at cycle 5 → first wr_en at cycle 8 with entry 0.
- In DONE, start pulse → done clears next cycle; a full second pass occurs with identical spacing.
- Connect to the SPI writer → each frame decodes to the table addr/data and CSB never stays low across two requests.

Source files
------------

// File: rtl/ad_cfg_seq.sv
// ad_cfg_seq: walks a {addr,data} register table and issues one write request per
// entry, spacing requests so each downstream SPI frame finishes before the next.
module ad_cfg_seq #(
    parameter int NUM_REGS   = 16,
    parameter int IDX_W      = 5,
    parameter int GAP_CYCLES = 64,
    parameter int PWR_DLY    = 1000,
    parameter bit AUTO_START = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic [IDX_W-1:0] o_tbl_idx,
    input  logic [5:0]       i_tbl_addr,
    input  logic [7:0]       i_tbl_data,
    output logic             o_wr_en,
    output logic [5:0]       o_addr,
    output logic [7:0]       o_data,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PWR_WAIT = 3'd1,
        ST_FETCH    = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_GAP      = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    // With PWR_DLY=0 this wraps to all-ones, but PWR_WAIT is then never entered.
    localparam logic [19:0]      PWR_LAST = 20'(PWR_DLY - 1);
    localparam logic [9:0]       GAP_LAST = 10'(GAP_CYCLES - 1);
    localparam bit               HAS_PWR  = (PWR_DLY > 0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_cnt;
    logic [19:0]      r_pwr_cnt;
    logic [9:0]       r_gap_cnt;
    logic             r_wr_en;
    logic [5:0]       r_addr;
    logic [7:0]       r_data;
    logic             r_busy;
    logic             r_done;
    logic             r_auto;
    logic             w_accept;
    logic             w_issue;
    logic             w_finish;
    logic             w_advance;
    logic             w_pwr_exp;
    logic             w_gap_exp;

    assign w_pwr_exp = (r_pwr_cnt == PWR_LAST);
    assign w_gap_exp = (r_gap_cnt == GAP_LAST);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and one-cycle control strobes for the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_finish    = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                // r_auto only survives the first post-reset cycle, which is always IDLE.
                if (i_start || r_auto) begin
                    w_accept = 1'b1;
                    if (HAS_PWR) begin
                        w_state_nxt = ST_PWR_WAIT;
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_PWR_WAIT: begin
                if (w_pwr_exp) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_PWR_WAIT;
                end
            end
            ST_FETCH: begin
                w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_issue     = 1'b1;
                w_state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (w_gap_exp && (r_cnt == LAST_IDX)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (w_gap_exp) begin
                    w_advance   = 1'b1;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_GAP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: entry count, delay counters, write request and status flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_pwr_cnt <= 20'd0;
            r_gap_cnt <= 10'd0;
            r_wr_en   <= 1'b0;
            r_addr    <= 6'd0;
            r_data    <= 8'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_auto    <= AUTO_START;
        end else begin
            r_auto  <= 1'b0;
            r_wr_en <= w_issue;
            if (w_issue) begin
                r_addr <= i_tbl_addr;
                r_data <= i_tbl_data;
            end else begin
                r_addr <= r_addr;
                r_data <= r_data;
            end
            if (w_accept) begin
                r_cnt  <= '0;
                r_busy <= 1'b1;
                r_done <= 1'b0;
            end else if (w_finish) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else if (w_advance) begin
                r_cnt <= r_cnt + {{(IDX_W-1){1'b0}}, 1'b1};
            end else begin
                r_cnt <= r_cnt;
            end
            if ((r_state == ST_PWR_WAIT) && !w_pwr_exp) begin
                r_pwr_cnt <= r_pwr_cnt + 20'd1;
            end else begin
                r_pwr_cnt <= 20'd0;
            end
            // The wr_en cycle is the first GAP cycle, so the gap is counted from it.
            if ((r_state == ST_GAP) && !w_gap_exp) begin
                r_gap_cnt <= r_gap_cnt + 10'd1;
            end else begin
                r_gap_cnt <= 10'd0;
            end
        end
    end

    assign o_tbl_idx = r_cnt;
    assign o_wr_en   = r_wr_en;
    assign o_addr    = r_addr;
    assign o_data    = r_data;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: tb/tb_ad_cfg_seq.sv
// Scoreboard bench for ad_cfg_seq: random start/reset stimulus, expected write
// pulses and busy/done windows computed from cycle arithmetic on start acceptance.
module tb_ad_cfg_seq;

    localparam int NUM_REGS   = 4;
    localparam int IDX_W      = 5;
    localparam int GAP_CYCLES = 56;
    localparam int PWR_DLY    = 20;
    localparam int PERIOD     = GAP_CYCLES + 2;
    localparam int FIRST_WR   = 3 + PWR_DLY;
    localparam int PASS_LEN   = FIRST_WR + (NUM_REGS - 1) * PERIOD + GAP_CYCLES;

    logic             clk;
    logic             rst;
    logic             start;
    logic [IDX_W-1:0] tbl_idx;
    logic [5:0]       tbl_addr;
    logic [7:0]       tbl_data;
    logic             wr_en;
    logic [5:0]       addr;
    logic [7:0]       data;
    logic             busy;
    logic             done;

    ad_cfg_seq #(
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W),
        .GAP_CYCLES(GAP_CYCLES),
        .PWR_DLY   (PWR_DLY),
        .AUTO_START(1'b1)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .o_tbl_idx (tbl_idx),
        .i_tbl_addr(tbl_addr),
        .i_tbl_data(tbl_data),
        .o_wr_en   (wr_en),
        .o_addr    (addr),
        .o_data    (data),
        .o_busy    (busy),
        .o_done    (done)
    );

    logic [5:0] tab_a [32];
    logic [7:0] tab_d [32];
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered lookup table: data valid one cycle after the index.
    always @(posedge clk) begin
        tbl_addr <= tab_a[tbl_idx];
        tbl_data <= tab_d[tbl_idx];
    end

    typedef struct { int cyc; logic [5:0] a; logic [7:0] d; } wr_t;
    typedef struct { int eff; bit valid; int n; int d; bit is_rst; } ev_t;
    wr_t exp_q[$];
    ev_t ev_q[$];

    bit s_valid = 1'b0;
    int s_n = 0;
    int s_d = 0;
    bit prev_rst = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        else
            n_pass++;
    endtask

    task automatic post(bit v, int n, int d, bit r);
        ev_t e;
        e.eff = cyc + 1; e.valid = v; e.n = n; e.d = d; e.is_rst = r;
        ev_q.push_back(e);
        s_valid = v; s_n = n; s_d = d;
    endtask

    task automatic accept(int a);
        wr_t w;
        for (int k = 0; k < NUM_REGS; k++) begin
            w.cyc = a + FIRST_WR + k * PERIOD;
            w.a   = tab_a[k];
            w.d   = tab_d[k];
            exp_q.push_back(w);
        end
        post(1'b1, a, a + PASS_LEN, 1'b0);
    endtask

    task automatic step(bit r, bit s);
        @(posedge clk);
        #2;
        rst   = r;
        start = s;
        if (r) begin
            while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
            post(1'b0, 0, 0, 1'b1);
        end else if (prev_rst) begin
            accept(cyc);
        end else if (s && (!s_valid || cyc >= s_d)) begin
            accept(cyc);
        end
        prev_rst = r;
    endtask

    // Monitor: applies model events, then compares outputs away from the active edge.
    initial begin
        bit   chk_en = 1'b0;
        bit   m_valid = 1'b0;
        bit   skip;
        int   m_n = 0;
        int   m_d = 0;
        logic prev_wr = 1'b0;
        logic [5:0] prev_a = 6'd0;
        logic [7:0] prev_d = 8'd0;
        ev_t  e;
        wr_t  w;
        forever begin
            @(negedge clk);
            skip = 1'b0;
            while (ev_q.size() > 0 && ev_q[0].eff <= cyc) begin
                e = ev_q.pop_front();
                m_valid = e.valid; m_n = e.n; m_d = e.d;
                if (e.is_rst) begin
                    chk_en = 1'b1;
                    skip   = 1'b1;
                    chk("rst_addr", 32'(addr), 32'd0);
                    chk("rst_data", 32'(data), 32'd0);
                    chk("rst_idx", 32'(tbl_idx), 32'd0);
                end
            end
            if (chk_en) begin
                chk("busy", 32'(busy), 32'(m_valid && cyc > m_n && cyc < m_d));
                chk("done", 32'(done), 32'(m_valid && cyc >= m_d));
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    w = exp_q.pop_front();
                    chk("wr_en_pulse", 32'(wr_en), 32'd1);
                    chk("wr_addr", 32'(addr), 32'(w.a));
                    chk("wr_data", 32'(data), 32'(w.d));
                end else begin
                    chk("wr_en_idle", 32'(wr_en), 32'd0);
                end
                chk("idx_range", 32'(tbl_idx < NUM_REGS), 32'd1);
                if (!skip) begin
                    chk("wr_en_single", 32'(wr_en && prev_wr), 32'd0);
                    if (!wr_en) begin
                        chk("addr_hold", 32'(addr), 32'(prev_a));
                        chk("data_hold", 32'(data), 32'(prev_d));
                    end
                end
            end
            prev_wr = wr_en;
            prev_a  = addr;
            prev_d  = data;
        end
    end

    // Stimulus: auto-start, random starts/resets, mid-gap reset, held start.
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tab_a[i] = 6'($urandom);
            tab_d[i] = 8'($urandom);
        end
        repeat (3) step(1'b1, 1'b0);
        for (int i = 0; i < 700; i++)
            step($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0);
        // Reset during the gap after entry 1, then let auto-start rerun the pass.
        step(1'b1, 1'b0);
        for (int i = 0; i < FIRST_WR + PERIOD + 10; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, $urandom_range(0, 3) == 0);
        // Held start: back-to-back passes.
        for (int i = 0; i < 3 * PASS_LEN; i++) step(1'b0, 1'b1);
        for (int i = 0; i < PASS_LEN + 10; i++) step(1'b0, 1'b0);
        @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
